// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - MIPS fetch program counter with stall hold and pending redirect buffer
// BOOT -> RUN after reset; HOLD while stalled, buffering the latest redirect for the first unstalled edge.
module pc_unit #(
  parameter int              WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h8000_0180),
  parameter int              INC          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             exception,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             fetch_valid,
  output logic             redirect_pending
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int LW = (WIDTH < 28) ? WIDTH : 28;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] jump_tgt;
  logic [WIDTH-1:0] redir_tgt;
  logic             redir;
  logic [27:0]      jump_low;

  assign pc_plus4 = pc_q + WIDTH'(INC);
  assign jump_low = {jump_index, 2'b00};
  assign jump_tgt[LW-1:0] = jump_low[LW-1:0];

  // Narrow PCs simply keep the low bits of the 28-bit region target.
  generate
    if (WIDTH > 28) begin : g_jump_hi
      assign jump_tgt[WIDTH-1:28] = pc_plus4[WIDTH-1:28];
    end
  endgenerate

  always_comb begin
    redir     = jr | jump | branch_taken;
    redir_tgt = branch_target;
    if (jr) begin
      redir_tgt = jr_target;
    end else if (jump) begin
      redir_tgt = jump_tgt;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    case (state_q)
      // Only exception is sampled in BOOT so undriven redirect inputs cannot reach pc.
      BOOT: begin
        if (exception) begin
          pc_d    = EXC_VECTOR;
          state_d = stall ? HOLD : RUN;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        if (exception) begin
          pc_d       = EXC_VECTOR;
          pend_d     = 1'b0;
          pend_tgt_d = '0;
          state_d    = stall ? HOLD : RUN;
        end else if (!stall) begin
          state_d = RUN;
          pend_d  = 1'b0;
          if (redir) begin
            pc_d = redir_tgt;
          end else if (pend_q) begin
            pc_d = pend_tgt_q;
          end else begin
            pc_d = pc_plus4;
          end
        end else begin
          state_d = HOLD;
          if (redir) begin
            pend_d     = 1'b1;
            pend_tgt_d = redir_tgt;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc               = pc_q;
  assign fetch_valid      = (state_q == RUN);
  assign redirect_pending = pend_q;

endmodule
